key_input_conditioner: RTL and testbench

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

---
 rtl/key_input_conditioner.sv | 144 ++++++++++++++
 tb/tb_key_input_conditioner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
`default_nettype none
// key_input_conditioner: per-key sync, debounce, press/release pulses, optional auto-repeat.
// Auto-repeat hold FSM is built only when KEY_AUTOREPEAT_EN is defined.
module key_input_conditioner #(
  parameter int                N_KEYS               = 6,
  parameter int                DEBOUNCE_CYCLES      = 750000,
  parameter logic [N_KEYS-1:0] ACTIVE_LOW_MASK      = '0,
  parameter int                REPEAT_DELAY_CYCLES  = 37000000,
  parameter int                REPEAT_PERIOD_CYCLES = 7400000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_KEYS-1:0] i_keys,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_event
);

  localparam int            DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rpt_state_t;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
`endif

  // Polarity is normalised before synchronising so everything downstream sees 1 = pressed.
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_keys ^ ACTIVE_LOW_MASK;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [DB_W-1:0] db_cnt;
    logic            level;
    logic            press;
    logic            release_p;
    logic            rep;
    logic            toggle;

    // Toggle on the edge that completes DEBOUNCE_CYCLES consecutive disagreeing samples.
    assign toggle = (sync2[k] != level) && (db_cnt == DB_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        db_cnt    <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= toggle && !level;
        release_p <= toggle && level;
        if ((sync2[k] == level) || toggle) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
        if (toggle) begin
          level <= ~level;
        end
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    rpt_state_t       state;
    logic [RPT_W-1:0] hold_cnt;

    // A release on this edge forces IDLE first, so a coincident repeat is dropped.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        state    <= S_IDLE;
        hold_cnt <= '0;
        rep      <= 1'b0;
      end else begin
        rep <= 1'b0;
        if (toggle && level) begin
          state    <= S_IDLE;
          hold_cnt <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              hold_cnt <= '0;
              if (toggle) begin
                state <= S_DELAY;
              end
            end
            S_DELAY: begin
              if (hold_cnt == RD_LAST) begin
                state    <= S_REPEAT;
                hold_cnt <= '0;
                rep      <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            S_REPEAT: begin
              if (hold_cnt == RP_LAST) begin
                hold_cnt <= '0;
                rep      <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: begin
              state    <= S_IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end
`else
    assign rep = 1'b0;
`endif

    assign o_level[k]   = level;
    assign o_press[k]   = press;
    assign o_release[k] = release_p;
    assign o_event[k]   = press | rep;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_input_conditioner.sv
`default_nettype none
// Scoreboard bench for key_input_conditioner (N_KEYS=4, debounce 8, repeat 20/5, mask 4'b0010).
module tb_key_input_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] keys;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] evt;

  localparam logic [3:0] IDLE_KEYS = 4'b0010;

  key_input_conditioner #(
    .N_KEYS               (4),
    .DEBOUNCE_CYCLES      (8),
    .ACTIVE_LOW_MASK      (4'b0010),
    .REPEAT_DELAY_CYCLES  (20),
    .REPEAT_PERIOD_CYCLES (5)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_keys    (keys),
    .o_level   (level),
    .o_press   (press),
    .o_release (rel),
    .o_event   (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] evt;
    logic [3:0] lvl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] e, input logic [3:0] l);
    exp_t x;
    x.cyc = c; x.press = p; x.rel = r; x.evt = e; x.lvl = l;
    q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any pulse on press/release/event is a DUT output to be matched.
  always @(negedge clk) begin
    if (!rst && ((press | rel | evt) != 4'b0)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b evt=%b lvl=%b", cyc, press, rel, evt, level);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (x.cyc != cyc || x.press != press || x.rel != rel || x.evt != evt || x.lvl != level) begin
          errors++;
          $display("FAIL pulse got cyc=%0d press=%b rel=%b evt=%b lvl=%b want cyc=%0d press=%b rel=%b evt=%b lvl=%b",
                   cyc, press, rel, evt, level, x.cyc, x.press, x.rel, x.evt, x.lvl);
        end
      end
    end
  end

  int base;

  initial begin
    rst  = 1'b1;
    keys = IDLE_KEYS;
    step(3);
    checks++;
    if ({level, press, rel, evt} != 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0000", {level, press, rel, evt});
    end
    rst = 1'b0;
    step(5);

    // Clean press/release on key0
    base = cyc;
    keys = 4'b0011;
    push(base + 10, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    step(12);
    keys = IDLE_KEYS;
    push(base + 22, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(30);

    // 3-cycle glitches never qualify
    for (int i = 0; i < 8; i++) begin
      keys = 4'b0011;
      step(3);
      keys = IDLE_KEYS;
      step(3);
    end
    step(20);
    checks++;
    if (level != 4'b0000) begin
      errors++;
      $display("FAIL glitch_level got %b want 0000", level);
    end

    // Long hold: repeats at 30..70, release lands at 72 off the repeat grid
    base = cyc;
    keys = 4'b0011;
    push(base + 10, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = 30; t <= 70; t += 5) push(base + t, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    step(62);
    keys = IDLE_KEYS;
    push(base + 72, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(30);

    // Active-low key1 plus keys 2,3 in the same cycle
    base = cyc;
    keys = 4'b1100;
    push(base + 10, 4'b1110, 4'b0000, 4'b1110, 4'b1110);
    step(12);
    keys = IDLE_KEYS;
    push(base + 22, 4'b0000, 4'b1110, 4'b0000, 4'b0000);
    step(30);

    // Reset mid-hold: outputs drop at once, no release, fresh press after reset
    base = cyc;
    keys = 4'b0011;
    push(base + 10, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    step(25);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({level, press, rel, evt} != 16'h0) begin
      errors++;
      $display("FAIL reset_midhold got %h want 0000", {level, press, rel, evt});
    end
    step(2);
    rst = 1'b0;
    push(base + 37, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    step(13);
    keys = IDLE_KEYS;
    push(base + 50, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(30);

    // Release coincides with a due repeat at 70: release wins
    base = cyc;
    keys = 4'b0011;
    push(base + 10, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = 30; t <= 65; t += 5) push(base + t, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    step(60);
    keys = IDLE_KEYS;
    push(base + 70, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(30);

    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse got none want cyc=%0d press=%b rel=%b evt=%b lvl=%b",
               x.cyc, x.press, x.rel, x.evt, x.lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
